// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
// Bundles the pipeline-side signals of the next-PC controller.
//   master : drives fetch/hazard/ID/CP0 inputs, observes PC controls
//   slave  : the pc_sequencer itself
// Inputs to the sequencer : pc_current, stall, mdu_busy, branch_taken,
//                           branch_target, jump_valid, jump_target,
//                           exc_req, eret_req, epc
// Outputs of the sequencer: pc_enable, pc_next, flush_if, flush_id,
//                           pend_valid, stall_count
interface pc_sequencer_if;
  logic [31:0] pc_current;
  logic        stall;
  logic        mdu_busy;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic        pc_enable;
  logic [31:0] pc_next;
  logic        flush_if;
  logic        flush_id;
  logic        pend_valid;
  logic [31:0] stall_count;

  modport master (
    output pc_current, stall, mdu_busy, branch_taken, branch_target,
           jump_valid, jump_target, exc_req, eret_req, epc,
    input  pc_enable, pc_next, flush_if, flush_id, pend_valid, stall_count
  );

  modport slave (
    input  pc_current, stall, mdu_busy, branch_taken, branch_target,
           jump_valid, jump_target, exc_req, eret_req, epc,
    output pc_enable, pc_next, flush_if, flush_id, pend_valid, stall_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Next-PC controller: selects the next fetch address from sequential,
// branch/jump, exception and eret paths, buffers one redirect that shows
// up while the front end is held, and counts held cycles.
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous, active-high reset
//   bus    : pc_sequencer_if.slave (see interface header for signals)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RUN       | front end advancing, nothing buffered
// HOLD      | front end held, nothing buffered
// HOLD_PEND | a redirect target sits in pend_tgt, waiting for hold to drop
module pc_sequencer #(
  parameter logic [31:0] EXC_VECTOR = 32'h00400004
) (
  input logic          clock,
  input logic          reset,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HOLD      = 2'd1,
    HOLD_PEND = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pend_tgt;
  logic [31:0] stall_cnt;

  logic        hold;
  logic        redir_req;
  logic [31:0] redir_tgt;
  logic        load_pend;
  logic [31:0] pend_src;

  assign hold      = bus.stall | bus.mdu_busy;
  assign redir_req = bus.jump_valid | bus.branch_taken;
  assign redir_tgt = bus.jump_valid ? bus.jump_target : bus.branch_target;

  // eret under hold is buffered the same way as a branch; once something is
  // buffered, the stalled ID instruction keeps re-presenting it, so later
  // requests are ignored.
  assign load_pend = !bus.exc_req && hold && (state != HOLD_PEND) &&
                     (bus.eret_req || redir_req);
  assign pend_src  = bus.eret_req ? bus.epc : redir_tgt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (bus.exc_req) begin
      state_next = RUN;
    end else if (state == HOLD_PEND) begin
      state_next = hold ? HOLD_PEND : RUN;
    end else if (bus.eret_req || redir_req) begin
      state_next = hold ? HOLD_PEND : RUN;
    end else begin
      state_next = hold ? HOLD : RUN;
    end
  end

  always_comb begin
    bus.pc_enable = 1'b0;
    bus.pc_next   = bus.pc_current;
    bus.flush_if  = 1'b0;
    bus.flush_id  = 1'b0;
    if (!reset) begin
      if (bus.exc_req) begin
        bus.pc_enable = 1'b1;
        bus.pc_next   = EXC_VECTOR;
        bus.flush_if  = 1'b1;
        bus.flush_id  = 1'b1;
      end else if (state == HOLD_PEND) begin
        if (!hold) begin
          bus.pc_enable = 1'b1;
          bus.pc_next   = pend_tgt;
          bus.flush_if  = 1'b1;
        end
      end else if (bus.eret_req) begin
        if (!hold) begin
          bus.pc_enable = 1'b1;
          bus.pc_next   = bus.epc;
          bus.flush_if  = 1'b1;
        end
      end else if (redir_req) begin
        if (!hold) begin
          bus.pc_enable = 1'b1;
          bus.pc_next   = redir_tgt;
          bus.flush_if  = 1'b1;
        end
      end else if (!hold) begin
        bus.pc_enable = 1'b1;
        bus.pc_next   = bus.pc_current + 32'd4;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_tgt <= 32'd0;
    end else if (bus.exc_req) begin
      pend_tgt <= 32'd0;
    end else if (load_pend) begin
      pend_tgt <= pend_src;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt <= 32'd0;
    end else if (!bus.pc_enable && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign bus.pend_valid  = (state == HOLD_PEND);
  assign bus.stall_count = stall_cnt;

endmodule
